// File: rtl/fifo_rr_arbiter_tmr_if.sv
// Handshake bundle between the TMR round-robin arbiter, its source FIFOs and the readout FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface fifo_rr_arbiter_tmr_if #(
  parameter int N_SRC = 4,
  parameter int GNT_W = 2
);
  logic [N_SRC-1:0] src_almst_empty_i;
  logic [N_SRC-1:0] src_rd_o;
  logic             dst_almst_full_i;
  logic             dst_wr_o;
  logic [GNT_W-1:0] grant_o;
  logic             busy_o;
  logic             warn_o;

  modport master (
    input  src_almst_empty_i, dst_almst_full_i,
    output src_rd_o, dst_wr_o, grant_o, busy_o, warn_o
  );

  modport slave (
    output src_almst_empty_i, dst_almst_full_i,
    input  src_rd_o, dst_wr_o, grant_o, busy_o, warn_o
  );
endinterface

// File: rtl/fifo_rr_arbiter_tmr.sv
// Round-robin drain of N_SRC source FIFOs into one destination in bursts of up to BURST_LEN reads.
// Read one cycle after grant, write one cycle after read; almost-full/empty flags end a burst at the next edge.
module fifo_rr_arbiter_tmr #(
  parameter int N_SRC     = 4,
  parameter int GNT_W     = 2,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fifo_rr_arbiter_tmr_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [GNT_W-1:0] LAST_SRC = GNT_W'(N_SRC - 1);

  // Three copies of every protected register; logic only ever sees the voted value.
  logic [1:0]       st_q0, st_q1, st_q2;
  logic [GNT_W-1:0] ptr_q0, ptr_q1, ptr_q2;
  logic [GNT_W-1:0] gnt_q0, gnt_q1, gnt_q2;
  logic [CNT_W-1:0] cnt_q0, cnt_q1, cnt_q2;

  state_t           state_v;
  logic [GNT_W-1:0] ptr_v, gnt_v;
  logic [CNT_W-1:0] cnt_v;

  assign state_v = state_t'((st_q0 & st_q1) | (st_q0 & st_q2) | (st_q1 & st_q2));
  assign ptr_v   = (ptr_q0 & ptr_q1) | (ptr_q0 & ptr_q2) | (ptr_q1 & ptr_q2);
  assign gnt_v   = (gnt_q0 & gnt_q1) | (gnt_q0 & gnt_q2) | (gnt_q1 & gnt_q2);
  assign cnt_v   = (cnt_q0 & cnt_q1) | (cnt_q0 & cnt_q2) | (cnt_q1 & cnt_q2);

  logic mismatch;
  assign mismatch = (|(st_q0 ^ st_q1))   | (|(st_q1 ^ st_q2))
                  | (|(ptr_q0 ^ ptr_q1)) | (|(ptr_q1 ^ ptr_q2))
                  | (|(gnt_q0 ^ gnt_q1)) | (|(gnt_q1 ^ gnt_q2))
                  | (|(cnt_q0 ^ cnt_q1)) | (|(cnt_q1 ^ cnt_q2));

  // A double upset can leave the pointer or grant outside the source range.
  logic bad_idx;
  assign bad_idx = (32'(ptr_v) >= 32'(N_SRC)) || (32'(gnt_v) >= 32'(N_SRC));

  logic             found;
  logic [GNT_W-1:0] sel;
  logic [GNT_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = GNT_W'((int'(ptr_v) + i) % N_SRC);
      if (!found && !bus.src_almst_empty_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  state_t           state_d;
  logic [GNT_W-1:0] ptr_d, gnt_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    state_d = state_v;
    ptr_d   = ptr_v;
    gnt_d   = gnt_v;
    cnt_d   = cnt_v;
    if (bad_idx) begin
      state_d = IDLE;
      ptr_d   = '0;
      gnt_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_v)
        IDLE: state_d = ARB;
        ARB: begin
          if (found && !bus.dst_almst_full_i) begin
            gnt_d   = sel;
            cnt_d   = '0;
            state_d = BURST;
          end
        end
        BURST: begin
          cnt_d = cnt_v + 1'b1;
          if (cnt_v == LAST_CNT || bus.src_almst_empty_i[gnt_v] || bus.dst_almst_full_i)
            state_d = DRAIN;
        end
        DRAIN: begin
          ptr_d   = (gnt_v == LAST_SRC) ? '0 : gnt_v + 1'b1;
          state_d = ARB;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [N_SRC-1:0] rd;
  logic             dst_wr_q;
  logic             warn_q;

  always_comb begin
    rd = '0;
    for (int i = 0; i < N_SRC; i++)
      rd[i] = (state_v == BURST) && !bad_idx && (gnt_v == GNT_W'(i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q0    <= IDLE;
      st_q1    <= IDLE;
      st_q2    <= IDLE;
      ptr_q0   <= '0;
      ptr_q1   <= '0;
      ptr_q2   <= '0;
      gnt_q0   <= '0;
      gnt_q1   <= '0;
      gnt_q2   <= '0;
      cnt_q0   <= '0;
      cnt_q1   <= '0;
      cnt_q2   <= '0;
      dst_wr_q <= 1'b0;
      warn_q   <= 1'b0;
    end else begin
      st_q0    <= state_d;
      st_q1    <= state_d;
      st_q2    <= state_d;
      ptr_q0   <= ptr_d;
      ptr_q1   <= ptr_d;
      ptr_q2   <= ptr_d;
      gnt_q0   <= gnt_d;
      gnt_q1   <= gnt_d;
      gnt_q2   <= gnt_d;
      cnt_q0   <= cnt_d;
      cnt_q1   <= cnt_d;
      cnt_q2   <= cnt_d;
      dst_wr_q <= |rd;
      warn_q   <= mismatch;
    end
  end

  assign bus.src_rd_o = rd;
  assign bus.dst_wr_o = dst_wr_q;
  assign bus.grant_o  = gnt_v;
  assign bus.busy_o   = (state_v == BURST) || (state_v == DRAIN);
  assign bus.warn_o   = warn_q;

endmodule

// File: tb/tb_fifo_rr_arbiter_tmr.sv
// Bench for fifo_rr_arbiter_tmr: reset/idle vector table plus burst scoreboard for the multi-cycle cases.
module tb_fifo_rr_arbiter_tmr;
  localparam int N_SRC     = 4;
  localparam int GNT_W     = 2;
  localparam int BURST_LEN = 16;
  localparam int CNT_W     = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  fifo_rr_arbiter_tmr_if #(.N_SRC(N_SRC), .GNT_W(GNT_W)) bus ();

  fifo_rr_arbiter_tmr #(
    .N_SRC(N_SRC), .GNT_W(GNT_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] empty;
    logic       full;
    int         cyc;
    logic [3:0] rd;
    logic       wr;
    logic       busy;
    logic [1:0] gnt;
    logic       warn;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    int src;
    int len;
    int gap;   // -1: gap not checked
  } burst_t;

  burst_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst monitor: each completed read burst is popped from the scoreboard and compared.
  logic [3:0] cur_rd;
  logic       in_burst;
  logic       prev_rd_any;
  int         cur_len, cur_gap, gap, rd_tot, wr_tot;

  task automatic end_burst();
    burst_t e;
    int     got;
    got = -1;
    for (int k = 0; k < N_SRC; k++) if (cur_rd[k]) got = k;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_burst: got src %0d len %0d expected none", got, cur_len);
    end else begin
      e = sb.pop_front();
      chk("burst_src", 32'(got), 32'(e.src));
      chk("burst_len", 32'(cur_len), 32'(e.len));
      if (e.gap >= 0) chk("burst_gap", 32'(cur_gap), 32'(e.gap));
      chk("reads_eq_writes", 32'(wr_tot), 32'(rd_tot));
    end
  endtask

  initial begin
    logic [3:0] one;
    in_burst = 0; prev_rd_any = 0; gap = -1; rd_tot = 0; wr_tot = 0;
    cur_rd = '0; cur_len = 0; cur_gap = -1;
    forever begin
      @(negedge clk_i or posedge rst_i);
      if (rst_i) begin
        in_burst = 0; prev_rd_any = 0; gap = -1; rd_tot = 0; wr_tot = 0;
      end else begin
        chk("dst_wr_follows_rd", 32'(bus.dst_wr_o), 32'(prev_rd_any));
        if (bus.dst_wr_o) wr_tot++;
        if (bus.src_rd_o != '0) begin
          rd_tot++;
          if (!in_burst) begin
            in_burst = 1; cur_rd = bus.src_rd_o; cur_len = 0; cur_gap = gap;
          end
          one = 4'b0001;
          chk("rd_stable", 32'(bus.src_rd_o), 32'(cur_rd));
          chk("rd_matches_grant", 32'(bus.src_rd_o), 32'(one << bus.grant_o));
          cur_len++;
        end else if (in_burst) begin
          in_burst = 0;
          gap = 1;
          end_burst();
        end else if (gap >= 0) begin
          gap++;
        end
        prev_rd_any = |bus.src_rd_o;
      end
    end
  end

  task automatic do_reset(input logic [3:0] empty, input logic full);
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.src_almst_empty_i = empty;
    bus.dst_almst_full_i  = full;
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_rd(input logic [3:0] pat, input string name);
    int n = 0;
    while (bus.src_rd_o !== pat && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 32'(bus.src_rd_o), 32'(pat));
  endtask

  task automatic wait_sb(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic push(input int src, input int len, input int g);
    burst_t e;
    e.src = src; e.len = len; e.gap = g;
    sb.push_back(e);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{rst:1'b1, empty:4'b0000, full:1'b0, cyc:2,  rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd0};
    vecs[1] = '{rst:1'b1, empty:4'b1111, full:1'b1, cyc:2,  rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd0};
    vecs[2] = '{rst:1'b0, empty:4'b1111, full:1'b0, cyc:1,  rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd1};
    vecs[3] = '{rst:1'b0, empty:4'b1111, full:1'b0, cyc:20, rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd1};
    vecs[4] = '{rst:1'b0, empty:4'b1111, full:1'b1, cyc:5,  rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd1};
    vecs[5] = '{rst:1'b0, empty:4'b0000, full:1'b1, cyc:5,  rd:4'b0, wr:1'b0, busy:1'b0, gnt:2'd0, warn:1'b0, st:2'd1};

    rst_i = 1'b1;
    bus.src_almst_empty_i = 4'b1111;
    bus.dst_almst_full_i  = 1'b0;

    // Reset and idle behaviour
    for (int v = 0; v < 6; v++) begin
      @(negedge clk_i);
      rst_i = vecs[v].rst;
      bus.src_almst_empty_i = vecs[v].empty;
      bus.dst_almst_full_i  = vecs[v].full;
      repeat (vecs[v].cyc) @(negedge clk_i);
      chk($sformatf("vec%0d_rd", v),    32'(bus.src_rd_o), 32'(vecs[v].rd));
      chk($sformatf("vec%0d_wr", v),    32'(bus.dst_wr_o), 32'(vecs[v].wr));
      chk($sformatf("vec%0d_busy", v),  32'(bus.busy_o),   32'(vecs[v].busy));
      chk($sformatf("vec%0d_grant", v), 32'(bus.grant_o),  32'(vecs[v].gnt));
      chk($sformatf("vec%0d_warn", v),  32'(bus.warn_o),   32'(vecs[v].warn));
      chk($sformatf("vec%0d_state", v), 32'(dut.state_v),  32'(vecs[v].st));
    end

    // Only source 2 available: repeated full bursts from source 2
    do_reset(4'b1011, 1'b0);
    push(2, 16, -1);
    push(2, 16, 2);
    push(2, 16, 2);
    wait_sb("src2_bursts");

    // All sources available: rotation 0,1,2,3,0
    do_reset(4'b0000, 1'b0);
    push(0, 16, -1);
    for (int s = 1; s <= 4; s++) push(s % N_SRC, 16, 2);
    wait_sb("rotation");

    // Destination fills on the 5th read of source 1
    do_reset(4'b0000, 1'b0);
    push(0, 16, -1);
    push(1, 5, 2);
    push(2, 16, -1);
    wait_rd(4'b0010, "wait_src1");
    repeat (4) @(negedge clk_i);
    bus.dst_almst_full_i = 1'b1;
    @(negedge clk_i);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      chk("full_hold_busy", 32'(bus.busy_o), 32'd0);
      chk("full_hold_rd", 32'(bus.src_rd_o), 32'd0);
    end
    bus.dst_almst_full_i = 1'b0;
    wait_sb("full_then_src2");

    // Upset in one copy of the state register mid-burst
    do_reset(4'b0000, 1'b0);
    push(0, 16, -1);
    push(1, 16, 2);
    wait_rd(4'b0001, "wait_src0");
    repeat (3) @(negedge clk_i);
    chk("warn_before_upset", 32'(bus.warn_o), 32'd0);
    force dut.st_q1 = 2'd1;
    #1 release dut.st_q1;
    @(negedge clk_i);
    chk("warn_pulse", 32'(bus.warn_o), 32'd1);
    chk("copy0_scrubbed", 32'(dut.st_q0), 32'd2);
    chk("copy1_scrubbed", 32'(dut.st_q1), 32'd2);
    chk("copy2_scrubbed", 32'(dut.st_q2), 32'd2);
    @(negedge clk_i);
    chk("warn_clears", 32'(bus.warn_o), 32'd0);
    wait_sb("upset_sequence");

    // Asynchronous reset pulse in the middle of a source-1 burst
    do_reset(4'b0000, 1'b0);
    push(0, 16, -1);
    wait_rd(4'b0010, "wait_src1_b");
    repeat (3) @(negedge clk_i);
    chk("pre_rst_wr", 32'(bus.dst_wr_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst_rd", 32'(bus.src_rd_o), 32'd0);
    chk("async_rst_wr", 32'(bus.dst_wr_o), 32'd0);
    chk("async_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("async_rst_grant", 32'(bus.grant_o), 32'd0);
    #1 rst_i = 1'b0;
    sb.delete();
    push(0, 16, -1);
    push(1, 16, 2);
    wait_sb("restart_at_src0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
